// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- MEM-stage sequencer for a fixed-latency word-wide SRAM.
//
// Takes the request held in the EX/MEM register and runs it against the SRAM.
// While an access is in flight, freeze holds every upstream pipeline register.
// Read data goes to the MEM/WB register with a one-cycle rd_valid strobe.
//
// Optional feature: define MEM_ADDR_CHECK_EN to reject requests that fall
// outside the SRAM window or are not word aligned. A rejected request skips
// the SRAM entirely and pulses addr_err. Without the macro, addr_err is
// always 0 and addresses wrap through truncation.
//
// Parameters:
//   WAIT_CYCLES  SRAM access time in cycles (1..15)
//   BASE_ADDR    byte address that maps to SRAM word 0
//   ADDR_W       SRAM word-address width
// Ports:
//   clk, rst     rising-edge clock, synchronous active-low reset
//   mem_r_en     read request from EX/MEM
//   mem_w_en     write request from EX/MEM (wins over mem_r_en)
//   alu_result   byte address of the request
//   st_val       store data
//   freeze       combinational hold for the upstream pipeline registers
//   rd_data      registered read data; rd_valid is its one-cycle strobe
//   addr_err     one-cycle strobe for a rejected address
//   sram_addr    registered SRAM word address
//   sram_wdata   registered SRAM write data
//   sram_we_n    registered active-low SRAM write strobe
//   sram_oe_n    registered active-low SRAM output enable
//   sram_rdata   SRAM read data
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       st_val,
  output logic              freeze,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              addr_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        count;
  logic              op_write;
  logic              bad;
  logic              req;
  logic              req_bad;
  logic [ADDR_W+1:0] offset;
  logic              unused_bits;

  assign req = mem_r_en | mem_w_en;

  // Only the low ADDR_W+2 bits of the difference survive the truncation,
  // so the subtraction is done at that width directly.
  assign offset = alu_result[ADDR_W+1:0] - BASE_ADDR[ADDR_W+1:0];

  // Byte-offset bits and (without the range check) the high address bits
  // are intentionally ignored.
  assign unused_bits = ^{offset[1:0], alu_result};

`ifdef MEM_ADDR_CHECK_EN
  // Computed with two extra bits so the window end cannot overflow.
  localparam logic [33:0] LIMIT = {2'b00, BASE_ADDR} + (34'd4 << ADDR_W);

  assign req_bad = (alu_result < BASE_ADDR)
                 | ({2'b00, alu_result} >= LIMIT)
                 | (alu_result[1:0] != 2'b00);
`else
  assign req_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = req_bad ? DONE : ACCESS;
      ACCESS:  if (count == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and SRAM interface registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= 4'd0;
      op_write   <= 1'b0;
      bad        <= 1'b0;
      rd_data    <= 32'd0;
      sram_addr  <= '0;
      sram_wdata <= 32'd0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_write   <= mem_w_en;
            bad        <= req_bad;
            sram_addr  <= offset[ADDR_W+1:2];
            sram_wdata <= st_val;
            count      <= 4'(WAIT_CYCLES - 1);
            if (!req_bad) begin
              sram_we_n <= ~mem_w_en;
              sram_oe_n <= mem_w_en;
            end else if (!mem_w_en) begin
              // A rejected read still completes, returning zero.
              rd_data <= 32'd0;
            end
          end
        end
        ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            // Final access edge: release strobes and sample the SRAM.
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!op_write) rd_data <= sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    freeze   = rst & (((state == IDLE) & req) | (state == ACCESS));
    rd_valid = (state == DONE) & ~op_write;
    addr_err = (state == DONE) & bad;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with WAIT_CYCLES=4, BASE_ADDR=1024.
module tb_mem_access_ctrl;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_val;
  logic        freeze;
  logic [31:0] rd_data;
  logic        rd_valid, addr_err;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we_n, sram_oe_n;
  logic [31:0] sram_rdata;
  logic [31:0] mem_word;

  always #5 clk = ~clk;

  // SRAM model: data is only driven while the output enable is active.
  assign sram_rdata = (!sram_oe_n) ? mem_word : 32'hBAD0_BAD0;

  mem_access_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'd1024),
    .ADDR_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .alu_result(alu_result),
    .st_val    (st_val),
    .freeze    (freeze),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .addr_err  (addr_err),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_rdata(sram_rdata)
  );

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] rdata;
    logic [15:0] exp_addr;
    bit          exp_bad;
  } vec_t;

  typedef struct {
    bit          rv;
    logic [31:0] rd;
    bit          ae;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one request starting in cycle 0 (caller is just after a rising
  // edge) and checks every cycle through DONE; returns at DONE's falling edge.
  task automatic run_access(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    int   lat;
    bit   strobe_on;
    mem_r_en   = v.r;
    mem_w_en   = v.w;
    alu_result = v.addr;
    st_val     = v.st;
    mem_word   = v.rdata;
    e.rv = v.r && !v.w;
    e.ae = v.exp_bad;
    e.rd = e.rv ? (v.exp_bad ? 32'd0 : v.rdata) : model_rd;
    model_rd = e.rd;
    sb.push_back(e);
    lat = v.exp_bad ? 0 : W;
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      strobe_on = (c >= 1) && (c <= lat);
      chk($sformatf("%s_freeze_c%0d", tag, c), freeze, (c <= lat));
      chk($sformatf("%s_we_n_c%0d", tag, c), sram_we_n, !(v.w && strobe_on));
      chk($sformatf("%s_oe_n_c%0d", tag, c), sram_oe_n, !(e.rv && strobe_on));
      if (c == 1 && !v.exp_bad) begin
        chk($sformatf("%s_addr", tag), sram_addr, v.exp_addr);
        chk($sformatf("%s_wdata", tag), sram_wdata, v.st);
      end
      if (c <= lat) begin
        chk($sformatf("%s_rd_valid_c%0d", tag, c), rd_valid, 1'b0);
      end else if (sb.size() == 0) begin
        chk($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
      end else begin
        g = sb.pop_front();
        chk($sformatf("%s_rd_valid_done", tag), rd_valid, g.rv);
        chk($sformatf("%s_addr_err_done", tag), addr_err, g.ae);
        chk($sformatf("%s_rd_data_done", tag), rd_data, g.rd);
      end
    end
    $display("txn %s w=%0d r=%0d addr=%0d sram_addr=%h rd_valid=%0d rd_data=%h addr_err=%0d",
             tag, v.w, v.r, v.addr, sram_addr, rd_valid, rd_data, addr_err);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    chk("idle_freeze", freeze, 1'b0);
    chk("idle_rd_valid", rd_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Vector table.
    vecs.push_back('{1'b1, 1'b0, 32'd1032,   32'hDEADBEEF, 32'h0,        16'd2,      1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd1028,   32'h0,        32'h12345678, 16'd1,      1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'd1040,   32'hA5A5A5A5, 32'h11111111, 16'd4,      1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd1024,   32'h0,        32'hCAFEF00D, 16'd0,      1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'd1424,   32'h00000001, 32'h0,        16'd100,    1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd263164, 32'h0,        32'h0F0F0F0F, 16'hFFFF,   1'b0});
`ifdef MEM_ADDR_CHECK_EN
    vecs.push_back('{1'b0, 1'b1, 32'd1000,   32'h0,        32'h55AA55AA, 16'd0,      1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'd1026,   32'h12121212, 32'h0,        16'd0,      1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'd263168, 32'h0,        32'h66666666, 16'd0,      1'b1});
`else
    vecs.push_back('{1'b0, 1'b1, 32'd1000,   32'h0,        32'h55AA55AA, 16'hFFFA,   1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd1030,   32'h0,        32'h77777777, 16'd1,      1'b0});
`endif

    // Reset state, with a pending request that must not raise freeze.
    rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b0;
    alu_result = 32'd1028; st_val = 32'h0; mem_word = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_oe_n", sram_oe_n, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_sram_addr", sram_addr, 16'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    mem_r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven single transactions with an idle cycle between.
    for (int i = 0; i < vecs.size(); i++) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
      go_idle();
    end

    // Back-to-back: write, then read accepted the cycle after DONE.
    run_access('{1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 32'h0, 16'd3, 1'b0}, "b2b_wr");
    @(posedge clk); #1;
    run_access('{1'b0, 1'b1, 32'd1044, 32'h0, 32'h89ABCDEF, 16'd5, 1'b0}, "b2b_rd");
    go_idle();

    // Reset abort in cycle 2 of a write.
    mem_w_en = 1'b1; mem_r_en = 1'b0; alu_result = 32'd1048; st_val = 32'h31415926;
    @(negedge clk);
    chk("abort_freeze_c0", freeze, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_we_n_c1", sram_we_n, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_freeze_c2", freeze, 1'b0);
    @(posedge clk); #1;
    mem_w_en = 1'b0;
    @(negedge clk);
    chk("abort_we_n_c3", sram_we_n, 1'b1);
    chk("abort_oe_n_c3", sram_oe_n, 1'b1);
    chk("abort_freeze_c3", freeze, 1'b0);
    chk("abort_rd_data_c3", rd_data, 32'd0);
    model_rd = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_rd_valid_p%0d", c), rd_valid, 1'b0);
      chk($sformatf("abort_freeze_p%0d", c), freeze, 1'b0);
    end
    $display("txn reset_abort rd_valid=%0d we_n=%0d", rd_valid, sram_we_n);

    // A normal read after the abort proves the FSM is back in IDLE.
    @(posedge clk); #1;
    run_access('{1'b0, 1'b1, 32'd1052, 32'h0, 32'hFEEDFACE, 16'd7, 1'b0}, "post_abort");
    go_idle();

    if (sb.size() != 0) chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
